// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the RV32M multi-cycle execute unit.
// - MD_XLEN: default datapath width.
// - md_op_e: funct3 encodings of the M-extension ops.
// - md_state_e: control FSM states.
// - Helpers that decode operand signedness and op class from md_op_e.
package ex_muldiv_pkg;

    localparam int unsigned MD_XLEN = 32;

    typedef enum logic [2:0] {
        MdMul    = 3'd0,
        MdMulh   = 3'd1,
        MdMulhsu = 3'd2,
        MdMulhu  = 3'd3,
        MdDiv    = 3'd4,
        MdDivu   = 3'd5,
        MdRem    = 3'd6,
        MdRemu   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } md_state_e;

    function automatic logic op_is_div(md_op_e op);
        return op inside {MdDiv, MdDivu, MdRem, MdRemu};
    endfunction

    function automatic logic op_is_rem(md_op_e op);
        return op inside {MdRem, MdRemu};
    endfunction

    function automatic logic op_rs1_signed(md_op_e op);
        return op inside {MdMulh, MdMulhsu, MdDiv, MdRem};
    endfunction

    function automatic logic op_rs2_signed(md_op_e op);
        return op inside {MdMulh, MdDiv, MdRem};
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Handshake/data bundle between the ID/EX pipeline stage and ex_muldiv.
// Signal names carry the direction as seen from the execute unit.
//   start_i/op_i/rs1_i/rs2_i/wd_i/flush_i : request side (driven by the pipeline)
//   result_o/valid_o/wd_o/stall_o/busy_o  : response side (driven by ex_muldiv)
// Modports: master = pipeline side, slave = execute unit.
interface ex_muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      wd_i;
    logic            flush_i;
    logic [XLEN-1:0] result_o;
    logic            valid_o;
    logic [4:0]      wd_o;
    logic            stall_o;
    logic            busy_o;

    modport master (
        output start_i, op_i, rs1_i, rs2_i, wd_i, flush_i,
        input  result_o, valid_o, wd_o, stall_o, busy_o
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, wd_i, flush_i,
        output result_o, valid_o, wd_o, stall_o, busy_o
    );
endinterface

// File: rtl/ex_muldiv_iter.sv
// Iterative step datapath for ex_muldiv: one shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle on a shared 2*XLEN accumulator.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   init_i     : load accumulator low half with lo_i, latch opnd_i, clear counter
//   step_i     : perform one iteration
//   is_div_i   : step kind (1 divide, 0 multiply)
//   lo_i       : multiplier (multiply) or dividend (divide), magnitude
//   opnd_i     : multiplicand (multiply) or divisor (divide), magnitude
//   acc_o      : multiply -> full product; divide -> {remainder, quotient}
//   last_o     : counter is at XLEN-1 (current step is the final one)
module ex_muldiv_iter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   lo_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic              last_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Extra bit holds the carry out of the add / the bit shifted out before compare.
    logic [XLEN:0] add_sum;
    logic [XLEN:0] rem_shift;
    logic [XLEN:0] rem_diff;

    always_comb begin
        add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_shift = acc_q[2*XLEN-1:XLEN-1];
        rem_diff  = rem_shift - {1'b0, opnd_q};

        acc_d  = acc_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;

        if (init_i) begin
            acc_d  = {{XLEN{1'b0}}, lo_i};
            opnd_d = opnd_i;
            cnt_d  = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + 1'b1;
            if (is_div_i) begin
                // Quotient bits enter at the bottom as dividend bits leave the top.
                if (rem_shift >= {1'b0, opnd_q}) begin
                    acc_d = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
            end else begin
                acc_d = {add_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign acc_o  = acc_q;
    assign last_o = (cnt_q == CNT_W'(XLEN - 1));

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multi-cycle execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Operates on operand magnitudes through ex_muldiv_iter, then restores signs in FIX.
// Divide-by-zero and signed overflow resolve in IDLE with one-cycle latency.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   md       : ex_muldiv_if.slave -- start/op/rs1/rs2/wd/flush in,
//              result/valid/wd/stall/busy out
// Build option: define BITTY_FAST_MUL_EN to compute multiplies combinationally
// in IDLE (1-cycle latency); divides always use the iterative path.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = MD_XLEN,
    parameter int unsigned CNT_W = 6
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave md
);

    md_state_e       state_q, state_d;
    md_op_e          op_q;
    logic            rs1_neg_q, rs2_neg_q;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      wd_q;

    md_op_e          op_in;
    logic            accept;
    logic            rs1_neg_in, rs2_neg_in;
    logic [XLEN-1:0] rs1_abs, rs2_abs;
    logic            div0, ovf, special;
    logic [XLEN-1:0] special_res;
    logic            fast_mul;
    logic [XLEN-1:0] fast_res;

    logic              iter_init, iter_step, iter_last;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    // Request decode
    always_comb begin
        op_in      = md_op_e'(md.op_i);
        accept     = (state_q == StIdle) && md.start_i && !md.flush_i;
        rs1_neg_in = op_rs1_signed(op_in) && md.rs1_i[XLEN-1];
        rs2_neg_in = op_rs2_signed(op_in) && md.rs2_i[XLEN-1];
        rs1_abs    = rs1_neg_in ? ('0 - md.rs1_i) : md.rs1_i;
        rs2_abs    = rs2_neg_in ? ('0 - md.rs2_i) : md.rs2_i;

        div0    = (md.rs2_i == '0);
        ovf     = (op_in inside {MdDiv, MdRem}) &&
                  (md.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&md.rs2_i);
        special = op_is_div(op_in) && (div0 || ovf);

        if (div0) begin
            special_res = op_is_rem(op_in) ? md.rs1_i : '1;
        end else begin
            special_res = op_is_rem(op_in) ? '0 : md.rs1_i;
        end
    end

`ifdef BITTY_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;

    // Sign-extend to 2*XLEN; the low 2*XLEN bits of the product are exact.
    always_comb begin
        fast_a    = {{XLEN{rs1_neg_in}}, md.rs1_i};
        fast_b    = {{XLEN{op_rs2_signed(op_in) && md.rs2_i[XLEN-1]}}, md.rs2_i};
        fast_prod = fast_a * fast_b;
        fast_mul  = !op_is_div(op_in);
        fast_res  = (op_in == MdMul) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`else
    assign fast_mul = 1'b0;
    assign fast_res = '0;
`endif

    ex_muldiv_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .init_i   (iter_init),
        .step_i   (iter_step),
        .is_div_i (op_is_div(op_q)),
        .lo_i     (op_is_div(op_in) ? rs1_abs : rs2_abs),
        .opnd_i   (op_is_div(op_in) ? rs2_abs : rs1_abs),
        .acc_o    (acc),
        .last_o   (iter_last)
    );

    // Sign fix-up and result select
    always_comb begin
        prod = (rs1_neg_q ^ rs2_neg_q) ? ('0 - acc) : acc;
        quo  = (rs1_neg_q ^ rs2_neg_q) ? ('0 - acc[XLEN-1:0]) : acc[XLEN-1:0];
        rem  = rs1_neg_q ? ('0 - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
        unique case (op_q)
            MdMul:                     fix_res = prod[XLEN-1:0];
            MdMulh, MdMulhsu, MdMulhu: fix_res = prod[2*XLEN-1:XLEN];
            MdDiv, MdDivu:             fix_res = quo;
            MdRem, MdRemu:             fix_res = rem;
            default:                   fix_res = '0;
        endcase
    end

    // Control FSM next state
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        iter_init = 1'b0;
        iter_step = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (special) begin
                        result_d = special_res;
                        state_d  = StDone;
                    end else if (fast_mul) begin
                        result_d = fast_res;
                        state_d  = StDone;
                    end else begin
                        iter_init = 1'b1;
                        state_d   = StCalc;
                    end
                end
            end
            StCalc: begin
                if (md.flush_i) begin
                    state_d = StIdle;
                end else begin
                    iter_step = 1'b1;
                    if (iter_last) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                if (md.flush_i) begin
                    state_d = StIdle;
                end else begin
                    result_d = fix_res;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            op_q      <= MdMul;
            rs1_neg_q <= 1'b0;
            rs2_neg_q <= 1'b0;
            result_q  <= '0;
            wd_q      <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (accept) begin
                op_q      <= op_in;
                rs1_neg_q <= rs1_neg_in;
                rs2_neg_q <= rs2_neg_in;
                wd_q      <= md.wd_i;
            end
        end
    end

    // result_q only changes on entry to DONE, so result_o holds between ops.
    assign md.result_o = result_q;
    assign md.wd_o     = wd_q;
    assign md.valid_o  = (state_q == StDone) && !md.flush_i;
    assign md.stall_o  = accept ||
                         (((state_q == StCalc) || (state_q == StFix)) && !md.flush_i);
    assign md.busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
    localparam int unsigned XLEN = 32;
`ifdef BITTY_FAST_MUL_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = XLEN + 2;
`endif
    localparam int DivLat = XLEN + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(XLEN)) md ();

    ex_muldiv #(
        .XLEN  (XLEN),
        .CNT_W (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .md  (md)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wd;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // RISC-V M-extension reference semantics in 64-bit arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'b0, a});
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return 32'(ua / ub);
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
        logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (op < 3'd4) return MulLat;
        if (b == 0 || ((op == 3'd4 || op == 3'd6) && ovf)) return 1;
        return DivLat;
    endfunction

    // Called just after a rising edge with the DUT idle; returns just after a
    // rising edge with the DUT idle again.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wd, input logic [31:0] exp,
                          input int lat);
        sb_t e;
        int  cyc;
        int  stalls;
        bit  got;
        e.res = exp;
        e.wd  = wd;
        sb_q.push_back(e);
        md.start_i = 1'b1;
        md.op_i    = op;
        md.rs1_i   = a;
        md.rs2_i   = b;
        md.wd_i    = wd;
        cyc    = 0;
        stalls = 0;
        got    = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            if (md.valid_o) begin
                got = 1'b1;
                check({name, " latency"}, cyc, lat);
                check({name, " stall_cycles"}, stalls, lat);
                check({name, " stall_in_done"}, {31'b0, md.stall_o}, 32'd0);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s: unexpected valid_o with empty scoreboard", name);
                end else begin
                    e = sb_q.pop_front();
                    check({name, " result"}, md.result_o, e.res);
                    check({name, " wd"}, {27'b0, md.wd_o}, {27'b0, e.wd});
                end
            end else if (md.stall_o) begin
                stalls++;
            end
            @(posedge clk);
            #1;
            md.start_i = 1'b0;
            cyc++;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no valid_o within %0d cycles, expected at %0d",
                     name, cyc, lat);
            sb_q.delete();
        end
    endtask

    vec_t vecs[$];
    int   valid_seen;

    initial begin
        md.start_i = 1'b0;
        md.op_i    = '0;
        md.rs1_i   = '0;
        md.rs2_i   = '0;
        md.wd_i    = '0;
        md.flush_i = 1'b0;
        rst        = 1'b0;

        vecs.push_back('{3'd5, 32'd100,        32'd7,          32'd14,         DivLat});
        vecs.push_back('{3'd7, 32'd100,        32'd7,          32'd2,          DivLat});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  DivLat});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  DivLat});
        vecs.push_back('{3'd6, 32'd7,          32'hFFFF_FFFE,  32'd1,          DivLat});
        vecs.push_back('{3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{3'd6, 32'd5,          32'd0,          32'd5,          1});
        vecs.push_back('{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{3'd7, 32'd5,          32'd0,          32'd5,          1});
        vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
        vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
        vecs.push_back('{3'd5, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          DivLat});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          MulLat});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  MulLat});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  MulLat});
        vecs.push_back('{3'd0, 32'h0001_0000,  32'h0001_0000,  32'd0,          MulLat});
        vecs.push_back('{3'd0, 32'd3,          32'd5,          32'd15,         MulLat});
        vecs.push_back('{3'd1, 32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  MulLat});

        #2;
        check("reset result_o", md.result_o, 32'd0);
        check("reset valid_o", {31'b0, md.valid_o}, 32'd0);
        check("reset wd_o", {27'b0, md.wd_o}, 32'd0);
        check("reset stall_o", {31'b0, md.stall_o}, 32'd0);
        check("reset busy_o", {31'b0, md.busy_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1),
                   vecs[i].exp, vecs[i].lat);
        end

        for (int i = 0; i < 10; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op($sformatf("rand%0d", i), op, a, b, 5'(i + 3), ref_md(op, a, b),
                   lat_of(op, a, b));
        end

        // start together with flush in IDLE is not accepted
        md.start_i = 1'b1;
        md.op_i    = 3'd5;
        md.rs1_i   = 32'd50;
        md.rs2_i   = 32'd5;
        md.wd_i    = 5'd30;
        md.flush_i = 1'b1;
        @(negedge clk);
        check("idle_flush stall_o", {31'b0, md.stall_o}, 32'd0);
        @(posedge clk);
        #1;
        md.start_i = 1'b0;
        md.flush_i = 1'b0;
        @(negedge clk);
        check("idle_flush busy_o", {31'b0, md.busy_o}, 32'd0);
        @(posedge clk);
        #1;

        // flush in CALC cycle 10
        md.start_i = 1'b1;
        md.op_i    = 3'd5;
        md.rs1_i   = 32'd1000;
        md.rs2_i   = 32'd3;
        md.wd_i    = 5'd7;
        @(posedge clk);
        #1;
        md.start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        md.flush_i = 1'b1;
        @(negedge clk);
        check("calc_flush busy_o", {31'b0, md.busy_o}, 32'd1);
        check("calc_flush valid_o", {31'b0, md.valid_o}, 32'd0);
        check("calc_flush stall_o", {31'b0, md.stall_o}, 32'd0);
        @(posedge clk);
        #1;
        md.flush_i = 1'b0;
        @(negedge clk);
        check("after_flush busy_o", {31'b0, md.busy_o}, 32'd0);
        valid_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (md.valid_o) valid_seen++;
        end
        check("after_flush valid_count", valid_seen, 32'd0);
        @(posedge clk);
        #1;
        run_op("post_flush_divu", 3'd5, 32'd9, 32'd3, 5'd9, 32'd3, DivLat);

        // async reset mid-CALC
        md.start_i = 1'b1;
        md.op_i    = 3'd5;
        md.rs1_i   = 32'd100;
        md.rs2_i   = 32'd7;
        md.wd_i    = 5'd21;
        @(posedge clk);
        #1;
        md.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("pre_reset busy_o", {31'b0, md.busy_o}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_reset result_o", md.result_o, 32'd0);
        check("mid_reset valid_o", {31'b0, md.valid_o}, 32'd0);
        check("mid_reset wd_o", {27'b0, md.wd_o}, 32'd0);
        check("mid_reset stall_o", {31'b0, md.stall_o}, 32'd0);
        check("mid_reset busy_o", {31'b0, md.busy_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_op("post_reset_remu", 3'd7, 32'd100, 32'd7, 5'd22, 32'd2, DivLat);

`ifdef BITTY_FAST_MUL_EN
        // back-to-back fast multiplies: one result every two cycles
        md.start_i = 1'b1;
        md.op_i    = 3'd0;
        md.rs1_i   = 32'd3;
        md.rs2_i   = 32'd5;
        md.wd_i    = 5'd4;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("b2b valid cycle%0d", c), {31'b0, md.valid_o},
                  {31'b0, (c % 2 == 1)});
            if (c % 2 == 1) check($sformatf("b2b result cycle%0d", c), md.result_o, 32'd15);
            @(posedge clk);
            #1;
        end
        md.start_i = 1'b0;
        @(posedge clk);
        #1;
`endif

        check("scoreboard drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised multi-cycle RV32M execute unit beside the single-cycle ALU in the EX stage.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with an iterative shift-add/shift-subtract datapath.
- Stalls the pipeline through ctrl while busy and presents a one-cycle-valid result to ex_mem.
- Generalises the execute datapath in width (XLEN) and adds sequential, stall-driven behaviour.

Parameters:
- XLEN, 32: operand/result width; also the iteration count.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-low
- start_i  in  1  id/ex holds a valid M-extension op
- op_i  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_i  in  XLEN  dividend / multiplicand
- rs2_i  in  XLEN  divisor / multiplier
- wd_i  in  5  destination register address
- flush_i  in  1  branch/exception flush; cancels the op in flight
- result_o  out  XLEN  result
- valid_o  out  1  result valid; one-cycle pulse
- wd_o  out  5  destination address latched at accept
- stall_o  out  1  stall request to ctrl
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst low, async): state IDLE, counter 0, all registers 0; result_o 0, valid_o 0, wd_o 0, stall_o 0, busy_o 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start_i=1 and flush_i=0 accepts the op (cycle 0): latch op, wd_i, |rs1|, |rs2|, sign flags.
  - Special case goes to DONE; otherwise counter clears and state goes to CALC.
- Signedness:
  - DIV/REM/MULH: both operands signed.
  - MULHSU: rs1 signed only.
  - All other ops: unsigned.
- CALC: one step per cycle, XLEN cycles (cycles 1..XLEN).
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract; quotient bit 1 when partial remainder >= divisor.
  - Counter reaching XLEN-1 moves state to FIX.
- FIX (cycle XLEN+1):
  - Negate product if operand signs differ.
  - Negate quotient if dividend sign != divisor sign.
  - Remainder takes the dividend sign.
  - Select MUL low half, MULH* high half, quotient or remainder; go to DONE.
- DONE (cycle XLEN+2 normal; cycle 1 special): valid_o=1, result_o/wd_o driven; always returns to IDLE. start_i is ignored in DONE.
- result_o holds its last value outside DONE; valid_o is 0 outside DONE.
- stall_o = (IDLE & start_i & ~flush_i) | CALC | FIX. It is 0 in DONE so the instruction advances.
- Special cases, resolved in IDLE with 1-cycle latency:
  - Divide by zero: DIV/DIVU quotient all ones; REM/REMU remainder = rs1.
  - Signed overflow (rs1 = 1<<(XLEN-1), rs2 = all ones): DIV quotient = rs1; REM remainder = 0.
- flush_i in CALC/FIX/DONE: next state IDLE, valid_o forced 0 that cycle, stall_o 0.
- flush_i together with start_i in IDLE: the op is not accepted.
- All arithmetic is modulo 2^XLEN except the 2*XLEN product accumulator.

Optional Feature:
- BITTY_FAST_MUL_EN defined:
  - Multiply ops compute the full 2*XLEN product combinationally in IDLE and go straight to DONE.
  - Latency 1 cycle; stall_o high for cycle 0 only.
- Not defined: multiply uses the iterative CALC/FIX path with XLEN+2 latency.
- Divide is unaffected either way.

Decomposition:
- Shared package/defines header (bitty_defs.v): op encodings (MD_MUL..MD_REMU), state encodings, MD_XLEN default.
- Natural sub-module: muldiv_iter, holding the accumulator/partial-remainder step datapath and counter.
- ex_muldiv keeps the FSM, special-case detection, sign fix-up and handshake.

Test Plan:
- DIVU 100/7 (non-fast): stall_o high cycles 0..33, valid_o in cycle 34, result_o=14; REMU 100/7 -> 2.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REM 7/-2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, valid_o in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF; MUL 0x10000*0x10000 -> 0.
- Assert flush_i in CALC cycle 10 -> IDLE next cycle, no valid_o; a new DIVU 9/3 then returns 3. Pulse rst low mid-CALC -> all outputs 0 immediately.
- With BITTY_FAST_MUL_EN: MUL 3*5 -> valid_o cycle 1, result 15; back-to-back MULs sustain one result every two cycles.
